// File: rtl/mlt3_pkg.sv
// Shared MLT-3 definitions: line levels, level stepping and serializer states.
package mlt3_pkg;

   typedef enum logic [1:0] {
      TOP    = 2'b00,
      DOWN   = 2'b01,
      BOTTOM = 2'b10,
      UP     = 2'b11
   } mlt3_level_t;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   // A '1' advances the line one level (wrapping UP -> TOP); a '0' holds it.
   function automatic mlt3_level_t next_level(input mlt3_level_t level, input logic bit_in);
      return mlt3_level_t'(level + {1'b0, bit_in});
   endfunction

endpackage

// File: rtl/mlt3_serializer.sv
// Handshake PISO: accepts a word, presents it MSB first, one bit per cycle.
//
// state | meaning
// IDLE  | no word held, ready for a new one
// SHIFT | presenting bit cnt of the held word; ready only on the last bit
module mlt3_serializer
   import mlt3_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data,
   input  logic              valid,
   output logic              ready,
   output logic              ser_bit,
   output logic              bit_valid
);

   localparam int CW = $clog2(DATA_W);
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   ser_state_t        state, state_next;
   logic [DATA_W-1:0] sr, sr_next;
   logic [CW-1:0]     cnt, cnt_next;

   // State, shift register and bit counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sr    <= '0;
         cnt   <= '0;
      end else begin
         state <= state_next;
         sr    <= sr_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state, shift and handshake decode; reloading on the last bit keeps words gapless.
   always_comb begin
      state_next = state;
      sr_next    = sr;
      cnt_next   = cnt;
      ready      = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (valid) begin
               sr_next    = data;
               cnt_next   = '0;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            sr_next  = {sr[DATA_W-2:0], 1'b0};
            cnt_next = cnt + CW'(1);
            if (cnt == LAST) begin
               ready    = 1'b1;
               cnt_next = '0;
               if (valid) begin
                  sr_next = data;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign ser_bit   = sr[DATA_W-1];
   assign bit_valid = (state == SHIFT);

endmodule

// File: rtl/mlt3_encoder.sv
// MLT-3 transmit encoder: serializer plus the line-level register and status flops.
module mlt3_encoder
   import mlt3_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_i,
   input  logic              valid_i,
   output logic              ready_o,
   output logic [1:0]        code_o,
   output logic              bit_strobe_o,
   output logic              busy_o
);

   logic        ready;
   logic        ser_bit;
   logic        bit_valid;
   mlt3_level_t level;

   mlt3_serializer #(.DATA_W(DATA_W)) u_ser (
      .clk       (clk),
      .rst       (rst),
      .data      (data_i),
      .valid     (valid_i),
      .ready     (ready),
      .ser_bit   (ser_bit),
      .bit_valid (bit_valid)
   );

   // Step the line level on each presented bit; busy tracks whether a word is held after this edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         level        <= TOP;
         bit_strobe_o <= 1'b0;
         busy_o       <= 1'b0;
      end else begin
         if (bit_valid) begin
            level <= next_level(level, ser_bit);
         end
         bit_strobe_o <= bit_valid;
         busy_o       <= (valid_i & ready) | (bit_valid & ~ready);
      end
   end

   assign ready_o = ready;
   assign code_o  = level;

endmodule

// File: tb/tb_mlt3_encoder.sv
// Directed bench for mlt3_encoder with hand-computed line levels.
module tb_mlt3_encoder;

   logic       clk;
   logic       rst;
   logic [7:0] data_i;
   logic       valid_i;
   logic       ready_o;
   logic [1:0] code_o;
   logic       bit_strobe_o;
   logic       busy_o;

   int tests_run;
   int tests_failed;

   mlt3_encoder #(.DATA_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .data_i       (data_i),
      .valid_i      (valid_i),
      .ready_o      (ready_o),
      .code_o       (code_o),
      .bit_strobe_o (bit_strobe_o),
      .busy_o       (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      valid_i = 1'b1;
      data_i  = 8'hFF;
      for (int i = 0; i < 2; i++) begin
         tick();
         tests_run++;
         if (code_o !== 2'b00 || ready_o !== 1'b1 || busy_o !== 1'b0 || bit_strobe_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state cyc%0d: code=%b ready=%b busy=%b strobe=%b, want code=00 ready=1 busy=0 strobe=0",
                     i, code_o, ready_o, busy_o, bit_strobe_o);
         end
      end
      rst     = 1'b0;
      valid_i = 1'b0;
      tick();
      tests_run++;
      if (busy_o !== 1'b0 || bit_strobe_o !== 1'b0 || code_o !== 2'b00) begin
         tests_failed++;
         $display("FAIL reset_no_accept: busy=%b strobe=%b code=%b, want busy=0 strobe=0 code=00",
                  busy_o, bit_strobe_o, code_o);
      end
   endtask

   task automatic test_word_ff();
      logic [1:0] exp [8] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
      data_i  = 8'hFF;
      valid_i = 1'b1;
      tests_run++;
      if (ready_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL ff_ready_idle: ready=%b, want 1", ready_o);
      end
      tick();
      valid_i = 1'b0;
      data_i  = 8'h00;
      tests_run++;
      if (busy_o !== 1'b1 || bit_strobe_o !== 1'b0 || code_o !== 2'b00) begin
         tests_failed++;
         $display("FAIL ff_accept: busy=%b strobe=%b code=%b, want busy=1 strobe=0 code=00",
                  busy_o, bit_strobe_o, code_o);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         tests_run++;
         if (code_o !== exp[i] || bit_strobe_o !== 1'b1 || busy_o !== (i < 7)) begin
            tests_failed++;
            $display("FAIL ff_bit%0d: code=%b strobe=%b busy=%b, want code=%b strobe=1 busy=%b",
                     i, code_o, bit_strobe_o, busy_o, exp[i], (i < 7));
         end
      end
      tick();
      tests_run++;
      if (bit_strobe_o !== 1'b0 || code_o !== 2'b00 || busy_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL ff_after: strobe=%b code=%b busy=%b, want strobe=0 code=00 busy=0",
                  bit_strobe_o, code_o, busy_o);
      end
   endtask

   task automatic test_word_a5_and_zero();
      logic [1:0] exp [8] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b00};
      data_i  = 8'hA5;
      valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         tests_run++;
         if (code_o !== exp[i] || bit_strobe_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL a5_bit%0d: code=%b strobe=%b, want code=%b strobe=1",
                     i, code_o, bit_strobe_o, exp[i]);
         end
      end
      tick();
      data_i  = 8'h00;
      valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         tests_run++;
         if (code_o !== 2'b00 || bit_strobe_o !== 1'b1 || busy_o !== (i < 7)) begin
            tests_failed++;
            $display("FAIL zero_bit%0d: code=%b strobe=%b busy=%b, want code=00 strobe=1 busy=%b",
                     i, code_o, bit_strobe_o, busy_o, (i < 7));
         end
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_code;
      logic       exp_ready;
      logic       exp_busy;
      logic       exp_strobe;
      data_i  = 8'h80;
      valid_i = 1'b1;
      tick();
      data_i  = 8'h01;
      for (int j = 0; j <= 16; j++) begin
         if (j > 0) tick();
         if (j == 15) valid_i = 1'b0;
         exp_code   = (j == 0) ? 2'b00 : (j == 16) ? 2'b10 : 2'b01;
         exp_ready  = (j == 7) || (j == 15) || (j == 16);
         exp_busy   = (j < 16);
         exp_strobe = (j >= 1);
         tests_run++;
         if (code_o !== exp_code || ready_o !== exp_ready || busy_o !== exp_busy || bit_strobe_o !== exp_strobe) begin
            tests_failed++;
            $display("FAIL b2b_j%0d: code=%b ready=%b busy=%b strobe=%b, want code=%b ready=%b busy=%b strobe=%b",
                     j, code_o, ready_o, busy_o, bit_strobe_o, exp_code, exp_ready, exp_busy, exp_strobe);
         end
      end
      tick();
   endtask

   task automatic test_hold_until_ready();
      logic [1:0] exp [8] = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
      data_i  = 8'h00;
      valid_i = 1'b1;
      tick();
      for (int j = 0; j < 8; j++) begin
         if (j > 0) tick();
         if (j < 7) begin
            data_i = 8'h11 * (j + 1);
            tests_run++;
            if (ready_o !== 1'b0) begin
               tests_failed++;
               $display("FAIL hold_ready_j%0d: ready=%b, want 0", j, ready_o);
            end
         end else begin
            data_i = 8'hC3;
         end
         tests_run++;
         if (code_o !== 2'b10) begin
            tests_failed++;
            $display("FAIL hold_code_j%0d: code=%b, want 10", j, code_o);
         end
      end
      tick();
      valid_i = 1'b0;
      data_i  = 8'hFF;
      tests_run++;
      if (code_o !== 2'b10 || busy_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL hold_reload: code=%b busy=%b, want code=10 busy=1", code_o, busy_o);
      end
      for (int i = 0; i < 8; i++) begin
         tick();
         tests_run++;
         if (code_o !== exp[i]) begin
            tests_failed++;
            $display("FAIL hold_c3_bit%0d: code=%b, want %b", i, code_o, exp[i]);
         end
      end
      tick();
      tests_run++;
      if (busy_o !== 1'b0 || code_o !== 2'b10) begin
         tests_failed++;
         $display("FAIL hold_end: busy=%b code=%b, want busy=0 code=10", busy_o, code_o);
      end
   endtask

   task automatic test_reset_mid_word();
      logic [1:0] exp [3] = '{2'b11, 2'b00, 2'b01};
      data_i  = 8'hFF;
      valid_i = 1'b1;
      tick();
      valid_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests_run++;
         if (code_o !== exp[i]) begin
            tests_failed++;
            $display("FAIL midrst_pre%0d: code=%b, want %b", i, code_o, exp[i]);
         end
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tests_run++;
      if (code_o !== 2'b00 || busy_o !== 1'b0 || ready_o !== 1'b1 || bit_strobe_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL midrst_state: code=%b busy=%b ready=%b strobe=%b, want code=00 busy=0 ready=1 strobe=0",
                  code_o, busy_o, ready_o, bit_strobe_o);
      end
      for (int i = 0; i < 10; i++) begin
         tick();
         tests_run++;
         if (code_o !== 2'b00 || bit_strobe_o !== 1'b0 || busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_quiet%0d: code=%b strobe=%b busy=%b, want code=00 strobe=0 busy=0",
                     i, code_o, bit_strobe_o, busy_o);
         end
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      valid_i      = 1'b0;
      data_i       = 8'h00;
      test_reset();
      test_word_ff();
      test_word_a5_and_zero();
      test_back_to_back();
      test_hold_until_ready();
      test_reset_mid_word();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
